jump_pc_ctrl: RTL and testbench
===============================

# jump_pc_ctrl

Fetch-sequencing controller for the ID-stage jump path. Owns the program counter and drives the instruction-memory request. Applies jump targets (26-bit index zero-extended to 32 bits) and ID-resolved branch targets. Generates the IF/ID flush and the redirect bubble. Sits between the hazard unit, the ID decoder and instruction memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of the redirect performance counter
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC, ignore redirects this cycle
- jump_valid  in  1  ID decoded J/JAL this cycle
- jump_index  in  26  instruction[25:0] of the jump
- branch_taken  in  1  ID resolved a taken branch this cycle
- branch_target  in  32  branch destination (word address)
- imem_ready  in  1  instruction memory accepted current fetch
- pc  out  32  current fetch address (word address)
- imem_req  out  1  fetch request valid
- flush_ifid  out  1  one-cycle kill of the IF/ID register
- redirect_count  out  CNT_W  number of redirects taken, saturating

## Operation
- States: BOOT, FETCH, REDIRECT.
- Reset (sampled high at an edge): state=BOOT, pc=RESET_PC, imem_req=0, flush_ifid=0, redirect_count=0. Reset overrides every other input, including mid-redirect.
- BOOT: imem_req=0. Unconditionally goes to FETCH at the next edge.
- FETCH: imem_req=1. Evaluated in this priority order:
  - stall=1: pc held, no redirect, stay in FETCH. ID re-presents the jump/branch after the stall clears.
  - branch_taken=1: pc<=branch_target.
  - else jump_valid=1: pc<={6'b0, jump_index}.
  - For either redirect: flush_ifid<=1, state<=REDIRECT, redirect_count increments (saturates at all-ones). A redirect does not depend on imem_ready.
  - No redirect and imem_ready=1: pc<=pc+1. Modulo 2^32, so 32'hFFFF_FFFF wraps to 0.
  - No redirect and imem_ready=0: pc held.
- REDIRECT: imem_req=0 and flush_ifid=1 for exactly this cycle. Any imem response in this cycle is discarded by the flush. jump_valid and branch_taken are ignored. Returns to FETCH at the next edge.
- Both branch_taken and jump_valid asserted: branch wins, counted once.

## Timing
- All outputs registered; no combinational input-to-output path.
- Redirect sampled at edge N: after N, pc=target, flush_ifid=1, imem_req=0. After N+1, imem_req=1 and flush_ifid=0, with fetch at target.
- Redirect cost: one bubble cycle.
- Sequential fetch throughput: one pc increment per cycle while imem_ready=1.
- After reset deasserts at edge R: BOOT during cycle R, first imem_req=1 with pc=RESET_PC after edge R+1.

## Structure
- Shared package pipeline_pkg holds:
  - state enum (BOOT, FETCH, REDIRECT)
  - PC_STEP=1
  - JUMP_EXT_W=6
- Target extension instantiates the existing `jump` 26-to-32 zero-extend module. No other sub-module.

## Test plan
- Reset with RESET_PC=32'h100, then imem_ready=1 for 3 cycles -> pc goes 100, 101, 102, 103; imem_req=1 from cycle 2; redirect_count=0.
- jump_valid=1, jump_index=26'h3FF_FFFF in FETCH -> next cycle pc=32'h03FF_FFFF, flush_ifid=1, imem_req=0; following cycle imem_req=1, flush_ifid=0; redirect_count=1.
- jump_valid=1 and branch_taken=1 with branch_target=32'h2000 -> pc=32'h2000, redirect_count increments by exactly 1.
- stall=1 with jump_valid=1 for 2 cycles, then stall=0 -> pc unchanged during the stall, redirect taken only after release; imem_ready=0 holds pc without redirect.
- pc=32'hFFFF_FFFF with imem_ready=1 -> pc=0. Force redirect_count to all-ones and redirect -> count stays 16'hFFFF.
- Assert reset during REDIRECT -> next cycle pc=RESET_PC, flush_ifid=0, imem_req=0, state BOOT.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the ID-stage jump / fetch sequencing path.
//   state_t    : fetch controller states (BOOT, FETCH, REDIRECT)
//   PC_STEP    : sequential fetch increment (word addressing)
//   JUMP_EXT_W : zero bits prepended to a 26-bit jump index
//   pc_step()  : next sequential pc, wraps modulo 2^32
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [31:0] PC_STEP    = 32'd1;
  localparam int          JUMP_EXT_W = 6;

  function automatic logic [31:0] pc_step(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/jump_pc_ctrl_if.sv
// Bus between the hazard unit / ID decoder / instruction memory and the
// fetch sequencing controller.
//   master : environment side, drives stall, jump/branch info, imem_ready
//   slave  : controller side, drives pc, imem_req, flush_ifid, redirect_count
interface jump_pc_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             jump_valid;
  logic [25:0]      jump_index;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             imem_ready;
  logic [31:0]      pc;
  logic             imem_req;
  logic             flush_ifid;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output stall, jump_valid, jump_index, branch_taken, branch_target, imem_ready,
    input  pc, imem_req, flush_ifid, redirect_count
  );

  modport slave (
    input  stall, jump_valid, jump_index, branch_taken, branch_target, imem_ready,
    output pc, imem_req, flush_ifid, redirect_count
  );
endinterface

// File: rtl/jump_pc_ctrl_jump.sv
// jump: zero-extends a 26-bit J/JAL instruction index to a 32-bit word
// address.
//   i_index  : instruction[25:0]
//   o_target : {6'b0, i_index}
module jump
  import pipeline_pkg::*;
(
  input  logic [25:0] i_index,
  output logic [31:0] o_target
);

  assign o_target = {{JUMP_EXT_W{1'b0}}, i_index};

endmodule

// File: rtl/jump_pc_ctrl.sv
// jump_pc_ctrl: owns the fetch pc, drives the instruction-memory request,
// applies jump / branch redirects with a one-cycle bubble and IF/ID flush,
// and counts redirects (saturating).
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave modport of jump_pc_ctrl_if (all outputs registered)
module jump_pc_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic           clock,
  input  logic           reset,
  jump_pc_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [31:0]      r_pc;
  logic             r_imem_req;
  logic             r_flush_ifid;
  logic [CNT_W-1:0] r_redirect_count;

  state_t           w_state_nxt;
  logic [31:0]      w_pc_nxt;
  logic             w_redirect;
  logic [CNT_W-1:0] w_count_nxt;
  logic [31:0]      w_jump_target;

  jump u_jump (
    .i_index  (bus.jump_index),
    .o_target (w_jump_target)
  );

  // Next-state and next-pc selection; branch outranks jump, stall blocks both.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_redirect  = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.stall) begin
          w_pc_nxt = r_pc;
        end else if (bus.branch_taken) begin
          w_pc_nxt   = bus.branch_target;
          w_redirect = 1'b1;
        end else if (bus.jump_valid) begin
          w_pc_nxt   = w_jump_target;
          w_redirect = 1'b1;
        end else if (bus.imem_ready) begin
          w_pc_nxt = pc_step(r_pc);
        end else begin
          w_pc_nxt = r_pc;
        end
        if (w_redirect) begin
          w_state_nxt = ST_REDIRECT;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      // Bubble cycle: jump/branch inputs ignored, imem response flushed.
      ST_REDIRECT: begin
        w_state_nxt = ST_FETCH;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // Saturating redirect counter increment.
  always_comb begin
    w_count_nxt = r_redirect_count;
    if (w_redirect && (r_redirect_count != CNT_MAX)) begin
      w_count_nxt = r_redirect_count + CNT_ONE;
    end else begin
      w_count_nxt = r_redirect_count;
    end
  end

  // State, pc, counter and output registers; outputs decode the next state
  // so they are valid in the same cycle the state is entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= ST_BOOT;
      r_pc             <= RESET_PC;
      r_imem_req       <= 1'b0;
      r_flush_ifid     <= 1'b0;
      r_redirect_count <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_pc             <= w_pc_nxt;
      r_imem_req       <= (w_state_nxt == ST_FETCH);
      r_flush_ifid     <= (w_state_nxt == ST_REDIRECT);
      r_redirect_count <= w_count_nxt;
    end
  end

  assign bus.pc             = r_pc;
  assign bus.imem_req       = r_imem_req;
  assign bus.flush_ifid     = r_flush_ifid;
  assign bus.redirect_count = r_redirect_count;

endmodule

// File: tb/tb_jump_pc_ctrl.sv
// Self-checking bench for jump_pc_ctrl: directed vector table, randomized
// traffic against a behavioural model, and a narrow-counter instance for
// redirect-count saturation.
module tb_jump_pc_ctrl;

  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam int          CNT_MAX = 65535;
  localparam int          SAT_MAX = 7;

  logic clock;
  logic reset;
  logic sreset;

  jump_pc_ctrl_if #(.CNT_W(16)) bus ();
  jump_pc_ctrl_if #(.CNT_W(3))  sbus ();

  jump_pc_ctrl #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  jump_pc_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(3)) dut_sat (
    .clock (clock),
    .reset (sreset),
    .bus   (sbus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // behavioural model: phase 0 = boot, 1 = fetching, 2 = bubble
  int          m_phase;
  logic [31:0] m_pc;
  int          m_cnt;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        jv;
    logic [25:0] idx;
    logic        bt;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_flush;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tv [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic st, input logic jv,
                       input logic [25:0] idx, input logic bt,
                       input logic [31:0] tgt, input logic rdy);
    reset             = rst;
    bus.stall         = st;
    bus.jump_valid    = jv;
    bus.jump_index    = idx;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    bus.imem_ready    = rdy;
    @(posedge clock);
    #1;
    if (rst) begin
      m_phase = 0;
      m_pc    = RST_PC;
      m_cnt   = 0;
    end else if (m_phase == 1 && !st && (bt || jv)) begin
      m_pc    = bt ? tgt : (32'd0 + idx);
      m_cnt   = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
      m_phase = 2;
    end else if (m_phase == 1 && !st && rdy) begin
      m_pc = m_pc + 32'd1;
    end else if (m_phase != 1) begin
      m_phase = 1;
    end
    chk("model_pc",    bus.pc, m_pc);
    chk("model_req",   {31'd0, bus.imem_req}, {31'd0, (m_phase == 1)});
    chk("model_flush", {31'd0, bus.flush_ifid}, {31'd0, (m_phase == 2)});
    chk("model_cnt",   {16'd0, bus.redirect_count}, m_cnt);
  endtask

  initial begin
    int flushes;
    logic [31:0] exp_sat;

    reset = 1'b1;
    bus.stall = 1'b0; bus.jump_valid = 1'b0; bus.jump_index = 26'd0;
    bus.branch_taken = 1'b0; bus.branch_target = 32'd0; bus.imem_ready = 1'b0;
    sreset = 1'b1;
    sbus.stall = 1'b0; sbus.jump_valid = 1'b0; sbus.jump_index = 26'd0;
    sbus.branch_taken = 1'b0; sbus.branch_target = 32'd0; sbus.imem_ready = 1'b0;
    m_phase = 0; m_pc = RST_PC; m_cnt = 0;

    //          rst   stall jv    idx           bt    tgt           rdy   e_pc          req   flush cnt
    tv[0]  = '{1'b1, 1'b0, 1'b0, 26'h0,       1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b0, 1'b0, 16'd0};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 26'h0,       1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b1, 1'b0, 16'd0};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 26'h0,       1'b0, 32'h0,        1'b1, 32'h0000_0101, 1'b1, 1'b0, 16'd0};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 26'h0,       1'b0, 32'h0,        1'b1, 32'h0000_0102, 1'b1, 1'b0, 16'd0};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 26'h0,       1'b0, 32'h0,        1'b1, 32'h0000_0103, 1'b1, 1'b0, 16'd0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 26'h3FF_FFFF, 1'b0, 32'h0,       1'b1, 32'h03FF_FFFF, 1'b0, 1'b1, 16'd1};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 26'h12,      1'b1, 32'h9999,     1'b1, 32'h03FF_FFFF, 1'b1, 1'b0, 16'd1};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 26'h12,      1'b1, 32'h2000,     1'b1, 32'h0000_2000, 1'b0, 1'b1, 16'd2};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 26'h0,       1'b0, 32'h0,        1'b0, 32'h0000_2000, 1'b1, 1'b0, 16'd2};
    tv[9]  = '{1'b0, 1'b1, 1'b1, 26'h55,      1'b0, 32'h0,        1'b1, 32'h0000_2000, 1'b1, 1'b0, 16'd2};
    tv[10] = '{1'b0, 1'b1, 1'b1, 26'h55,      1'b0, 32'h0,        1'b1, 32'h0000_2000, 1'b1, 1'b0, 16'd2};
    tv[11] = '{1'b0, 1'b0, 1'b1, 26'h55,      1'b0, 32'h0,        1'b1, 32'h0000_0055, 1'b0, 1'b1, 16'd3};
    tv[12] = '{1'b0, 1'b0, 1'b0, 26'h0,       1'b0, 32'h0,        1'b0, 32'h0000_0055, 1'b1, 1'b0, 16'd3};
    tv[13] = '{1'b0, 1'b0, 1'b0, 26'h0,       1'b0, 32'h0,        1'b0, 32'h0000_0055, 1'b1, 1'b0, 16'd3};
    tv[14] = '{1'b0, 1'b0, 1'b0, 26'h0,       1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 16'd4};
    tv[15] = '{1'b0, 1'b0, 1'b0, 26'h0,       1'b0, 32'h0,        1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 16'd4};
    tv[16] = '{1'b0, 1'b0, 1'b0, 26'h0,       1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 1'b0, 16'd4};
    tv[17] = '{1'b0, 1'b0, 1'b0, 26'h0,       1'b1, 32'h40,       1'b1, 32'h0000_0040, 1'b0, 1'b1, 16'd5};
    tv[18] = '{1'b1, 1'b0, 1'b1, 26'h7,       1'b1, 32'h80,       1'b1, 32'h0000_0100, 1'b0, 1'b0, 16'd0};
    tv[19] = '{1'b0, 1'b0, 1'b0, 26'h0,       1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b1, 1'b0, 16'd0};

    for (int i = 0; i < 20; i++) begin
      cycle(tv[i].rst, tv[i].stall, tv[i].jv, tv[i].idx, tv[i].bt, tv[i].tgt, tv[i].rdy);
      chk($sformatf("tv%0d_pc", i),    bus.pc, tv[i].e_pc);
      chk($sformatf("tv%0d_req", i),   {31'd0, bus.imem_req}, {31'd0, tv[i].e_req});
      chk($sformatf("tv%0d_flush", i), {31'd0, bus.flush_ifid}, {31'd0, tv[i].e_flush});
      chk($sformatf("tv%0d_cnt", i),   {16'd0, bus.redirect_count}, {16'd0, tv[i].e_cnt});
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 6) == 0), 26'($urandom),
            ($urandom_range(0, 8) == 0), $urandom,
            ($urandom_range(0, 3) != 0));
    end

    // saturation on the narrow-counter instance: jump requested every cycle
    @(posedge clock); #1;
    sreset = 1'b0;
    sbus.jump_valid = 1'b1;
    sbus.jump_index = 26'h123;
    sbus.imem_ready = 1'b1;
    flushes = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (sbus.flush_ifid) flushes++;
      exp_sat = (flushes < SAT_MAX) ? flushes : SAT_MAX;
      chk("sat_cnt", {29'd0, sbus.redirect_count}, exp_sat);
    end
    chk("sat_final_cnt", {29'd0, sbus.redirect_count}, 32'd7);
    chk("sat_final_pc", sbus.pc, 32'h0000_0123);
    chk("sat_enough_redirects", {31'd0, (flushes > SAT_MAX)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
